// File: rtl/adder_sum_decoder.sv
// adder_sum_decoder: bit-serial subtractor that recovers B = S - A from an adder sum S
// and a known operand A. One bit is processed per clock, LSB first. err is raised when
// the difference does not fit in an unsigned WIDTH-bit operand.
module adder_sum_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   S_in,
  input  logic [WIDTH-1:0] A_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B_out,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state;
  state_e         w_state_next;

  // r_s and r_a shift right each RUN cycle, so bit 0 is always the bit being processed.
  logic [WIDTH:0]  r_s;
  logic [WIDTH:0]  r_a;
  logic [WIDTH:0]  r_d;
  logic            r_borrow;
  logic [CntW-1:0] r_cnt;
  logic [WIDTH-1:0] r_b_out;
  logic            r_err;

  logic            w_accept;
  logic            w_last;
  logic            w_diff;
  logic            w_borrow_next;
  logic [WIDTH:0]  w_d_next;

  // Handshake and per-bit subtractor cell
  always_comb begin
    w_accept      = in_valid && in_ready;
    w_last        = (r_cnt == CntW'(WIDTH));
    w_diff        = r_s[0] ^ r_a[0] ^ r_borrow;
    w_borrow_next = (~r_s[0] & r_a[0]) | (~(r_s[0] ^ r_a[0]) & r_borrow);
    // Difference bits enter at the MSB; after WIDTH+1 shifts r_d holds the full D.
    w_d_next      = {w_diff, r_d[WIDTH:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = StRun;
      StRun:  if (w_last) w_state_next = StDone;
      StDone: if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: in_ready has no bypass from DONE, so a completing result and a new request
  // can never share an edge.
  always_comb begin
    in_ready  = (r_state == StIdle) && !rst;
    out_valid = (r_state == StDone);
    B_out     = r_b_out;
    err       = r_err;
  end

  // Datapath: operand capture, serial subtraction, result latch on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s      <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_b_out  <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_s      <= S_in;
            r_a      <= {1'b0, A_in};
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        StRun: begin
          r_s      <= r_s >> 1;
          r_a      <= r_a >> 1;
          r_d      <= w_d_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_b_out <= w_d_next[WIDTH-1:0];
            r_err   <= w_borrow_next | w_d_next[WIDTH];
          end
        end
        default: begin
          // DONE: hold result until the consumer takes it.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sum_decoder.sv
// Self-checking bench for adder_sum_decoder: directed boundary cases plus randomized
// round trips, all checked against an arithmetic model of S - A.
module tb_adder_sum_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] S_in;
  logic [7:0] A_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] B_out;
  logic       err;

  int total = 0;
  int bad   = 0;

  adder_sum_decoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S_in      (S_in),
    .A_in      (A_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .B_out     (B_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction, low 8 bits and range test.
  function automatic void model(input int s, input int a, output logic [7:0] b,
                                output logic e);
    int d;
    d = s - a;
    b = d[7:0];
    e = (d < 0) || (d > 255);
  endfunction

  // Drive one request, then count edges until out_valid (bounded).
  task automatic run_req(input int s, input int a, output int lat, output logic rdy_after,
                         output logic [7:0] b, output logic e);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    S_in     = s[8:0];
    A_in     = a[7:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rdy_after = in_ready;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    b = B_out;
    e = err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S_in = '0; A_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    total++;
    if ({out_valid, B_out, err} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b b=%0d e=%0b want 0/0/0", out_valid, B_out, err);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic rdy; logic [7:0] b; logic e;
    run_req(12, 5, lat, rdy, b, e);
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL basic_ready_fall got %0b want 0", rdy); end
    total++;
    if (lat != 9) begin bad++; $display("FAIL basic_latency got %0d want 9", lat); end
    total++;
    if (b !== 8'd7 || e !== 1'b0) begin
      bad++; $display("FAIL basic_result got b=%0d e=%0b want b=7 e=0", b, e);
    end
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_release got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes_and_errors();
    int s_tab[6] = '{510, 0, 255, 3, 300, 511};
    int a_tab[6] = '{255, 0, 255, 5, 10, 0};
    int lat; logic rdy; logic [7:0] b; logic e;
    logic [7:0] xb; logic xe;
    for (int i = 0; i < 6; i++) begin
      model(s_tab[i], a_tab[i], xb, xe);
      run_req(s_tab[i], a_tab[i], lat, rdy, b, e);
      total++;
      if (b !== xb || e !== xe || lat != 9) begin
        bad++;
        $display("FAIL boundary S=%0d A=%0d got b=%0d e=%0b lat=%0d want b=%0d e=%0b lat=9",
                 s_tab[i], a_tab[i], b, e, lat, xb, xe);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic rdy; logic [7:0] b; logic e;
    logic [7:0] xb; logic xe;
    model(60, 20, xb, xe);
    run_req(60, 20, lat, rdy, b, e);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || B_out !== xb || err !== xe) begin
        bad++;
        $display("FAIL hold_cycle%0d got v=%0b r=%0b b=%0d e=%0b want v=1 r=0 b=%0d e=%0b",
                 i, out_valid, in_ready, B_out, err, xb, xe);
      end
      @(posedge clk); #1;
    end
    release_out();
  endtask

  task automatic test_ignored_input();
    int lat; logic seen;
    S_in = 9'd40; A_in = 8'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    S_in = 9'd100; A_in = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    lat++;
    in_valid = 1'b0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 9 || B_out !== 8'd25 || err !== 1'b0) begin
      bad++;
      $display("FAIL ignored_input got lat=%0d b=%0d e=%0b want lat=9 b=25 e=0", lat, B_out, err);
    end
    release_out();
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL no_second_result got %0b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; logic rdy; logic [7:0] b; logic e;
    run_req(77, 7, lat, rdy, b, e);
    out_ready = 1'b1; in_valid = 1'b1; S_in = 9'd90; A_in = 8'd30;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_not_taken got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_taken_next got r=%0b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 9 || B_out !== 8'd60 || err !== 1'b0) begin
      bad++; $display("FAIL b2b_result got lat=%0d b=%0d e=%0b want lat=9 b=60 e=0", lat, B_out, err);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat; logic rdy; logic [7:0] b; logic e; logic seen;
    S_in = 9'd200; A_in = 8'd50; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got r=%0b v=%0b want r=0 v=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_recover got r=%0b want 1", in_ready); end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL discarded_result got %0b want 0", seen); end
    run_req(128, 28, lat, rdy, b, e);
    total++;
    if (b !== 8'd100 || e !== 1'b0 || lat != 9) begin
      bad++; $display("FAIL after_reset got b=%0d e=%0b lat=%0d want b=100 e=0 lat=9", b, e, lat);
    end
    release_out();
  endtask

  task automatic test_round_trip();
    int a, bb, lat; logic rdy; logic [7:0] b; logic e;
    logic [7:0] xb; logic xe;
    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, 255));
      bb = int'($urandom_range(0, 255));
      model(a + bb, a, xb, xe);
      run_req(a + bb, a, lat, rdy, b, e);
      total++;
      if (b !== xb || e !== xe || b !== bb[7:0]) begin
        bad++; $display("FAIL round_trip A=%0d B=%0d got b=%0d e=%0b", a, bb, b, e);
      end
      total++;
      if (lat != 9) begin bad++; $display("FAIL round_trip_latency got %0d want 9", lat); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes_and_errors();
    test_backpressure();
    test_ignored_input();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
